// File: rtl/seven_seg_pkg.sv
// Shared glyph table and constants for the seven-segment display path.
// Used by both the scanner/decoder pair and the capture side.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] segs;
  } seg_pair_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational segment-pattern to hex-nibble decode.
// Exact glyph match only; the blank pattern is reported separately.
module seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_segs,
  output logic [3:0] o_nibble,
  output logic       o_legal,
  output logic       o_blank
);

  always_comb begin
    o_nibble = 4'h0;
    o_legal  = 1'b1;
    o_blank  = 1'b0;
    case (i_segs)
      SEG_0: o_nibble = 4'h0;
      SEG_1: o_nibble = 4'h1;
      SEG_2: o_nibble = 4'h2;
      SEG_3: o_nibble = 4'h3;
      SEG_4: o_nibble = 4'h4;
      SEG_5: o_nibble = 4'h5;
      SEG_6: o_nibble = 4'h6;
      SEG_7: o_nibble = 4'h7;
      SEG_8: o_nibble = 4'h8;
      SEG_9: o_nibble = 4'h9;
      SEG_A: o_nibble = 4'hA;
      SEG_B: o_nibble = 4'hB;
      SEG_C: o_nibble = 4'hC;
      SEG_D: o_nibble = 4'hD;
      SEG_E: o_nibble = 4'hE;
      SEG_F: o_nibble = 4'hF;
      SEG_BLANK: begin
        o_legal = 1'b0;
        o_blank = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a scanned seven-segment display, filters scan glitches and
// reassembles the four digits into a 16-bit frame.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  segs,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [7:0] LP_SETTLE = 8'(SETTLE_CYCLES);
  localparam seg_pair_t  LP_IDLE   = '{anode: ANODE_OFF, segs: SEG_BLANK};

  seg_pair_t   r_pair;
  seg_pair_t   r_prev;
  logic [7:0]  r_cnt;
  logic [15:0] r_digits;
  logic [3:0]  r_blank;
  logic [3:0]  r_seen;

  logic        w_diff;
  logic        w_commit;
  logic [7:0]  w_cnt_nx;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic [3:0]  w_nibble;
  logic        w_legal;
  logic        w_blank;
  logic [15:0] w_digits_nx;
  logic [3:0]  w_blank_nx;
  logic [3:0]  w_seen_nx;
  logic        w_seg_err;
  logic        w_anode_err;
  logic        w_frame;

  seg_to_hex u_dec (
    .i_segs   (r_pair.segs),
    .o_nibble (w_nibble),
    .o_legal  (w_legal),
    .o_blank  (w_blank)
  );

  assign w_diff = (r_pair != r_prev);

  // Commit exactly once, on the edge the run length reaches the target.
  assign w_commit = !w_diff && (r_cnt == LP_SETTLE - 8'd1);

  always_comb begin
    w_cnt_nx = r_cnt + 8'd1;
    if (w_diff)
      w_cnt_nx = 8'd1;
    else if (r_cnt == LP_SETTLE)
      w_cnt_nx = r_cnt;
  end

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    unique case (r_pair.anode)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  always_comb begin
    w_digits_nx = r_digits;
    w_blank_nx  = r_blank;
    w_seen_nx   = r_seen;
    w_seg_err   = 1'b0;
    w_anode_err = 1'b0;
    if (w_commit && r_pair.anode != ANODE_OFF) begin
      if (!w_onehot) begin
        w_anode_err = 1'b1;
      end else if (w_legal) begin
        w_digits_nx[{w_idx, 2'b00} +: 4] = w_nibble;
        w_blank_nx[w_idx] = 1'b0;
        w_seen_nx[w_idx]  = 1'b1;
      end else if (w_blank) begin
        w_digits_nx[{w_idx, 2'b00} +: 4] = 4'h0;
        w_blank_nx[w_idx] = 1'b1;
        w_seen_nx[w_idx]  = 1'b1;
      end else begin
        w_seg_err        = 1'b1;
        w_seen_nx[w_idx] = 1'b0;
      end
    end
  end

  assign w_frame = w_commit && (&w_seen_nx);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pair      <= LP_IDLE;
      r_prev      <= LP_IDLE;
      r_cnt       <= 8'd0;
      r_digits    <= 16'h0;
      r_blank     <= 4'h0;
      r_seen      <= 4'h0;
      value       <= 16'h0;
      blank_mask  <= 4'h0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      r_pair      <= '{anode: anode, segs: segs};
      r_prev      <= r_pair;
      r_cnt       <= w_cnt_nx;
      r_digits    <= w_digits_nx;
      r_blank     <= w_blank_nx;
      frame_valid <= w_frame;
      seg_err     <= w_seg_err;
      anode_err   <= w_anode_err;
      if (w_frame) begin
        value      <= w_digits_nx;
        blank_mask <= w_blank_nx;
        r_seen     <= 4'h0;
      end else begin
        r_seen     <= w_seen_nx;
      end
    end
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive side of the multiplexed seven-segment display interface. It samples the active-low anode strobes and segment lines produced by the scanner/decoder pair and filters scan-transition glitches. It then decodes each stable segment pattern back to a hex nibble and reassembles the four digits into a 16-bit value with a one-cycle frame strobe. It sits in the bench harness and in the on-board loopback/self-check path, downstream of the display drivers.

## Interface
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is committed; legal range 2..255.
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- anode  in  4  display anodes, active-low one-hot; anode[0] = digit 0 (rightmost)
- segs  in  7  segments {g,f,e,d,c,b,a}, active-low
- value  out  16  last complete frame; digit n in value[4n+3:4n]
- blank_mask  out  4  bit n set = digit n was blank (segs 7'h7F) in last frame
- frame_valid  out  1  one-cycle pulse when value/blank_mask update
- seg_err  out  1  one-cycle pulse: committed pattern not a legal glyph
- anode_err  out  1  one-cycle pulse: committed anode has more than one low bit

## Operation
- Input stage: {anode, segs} registered every cycle; no other path reads raw pins.
- Stability counter: when the registered pair differs from the previous registered pair, the counter resets to 1. Otherwise it increments, saturating at SETTLE_CYCLES.
- Commit: fires exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES. It does not fire again until the pair changes.
- Commit actions by anode class:
  - 4'b1111 (all off): no action.
  - Multi-low: anode_err pulse; no digit update.
  - One-hot-low, index n:
    - segs legal glyph: digit[n] <= nibble, blank[n] <= 0, seen[n] <= 1.
    - segs == 7'h7F: digit[n] <= 0, blank[n] <= 1, seen[n] <= 1.
    - Any other segs: seg_err pulse, seen[n] <= 0.
- Glyphs (active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E. Exact match only.
- Frame: when the commit makes seen == 4'b1111, the following happen on that same edge:
  - value and blank_mask load the full digit/blank store, including the digit just committed.
  - frame_valid pulses.
  - seen clears to 0.
- Repeated digit before frame completes: overwrites, no error. Digit order is irrelevant.
- value and blank_mask hold between frames.

## Timing
- Reset (reset == 0 at a rising edge) clears the following; takes effect at that edge, including mid-dwell and mid-frame:
  - value = 0, blank_mask = 0, frame_valid = 0, seg_err = 0, anode_err = 0.
  - seen = 0, digit store = 0, input register = 4'hF/7'h7F, counter = 0.
- Latency: the new pair must be present at edges E..E+SETTLE_CYCLES−1. Commit effects (digit store, errors, frame outputs) are visible after edge E+SETTLE_CYCLES.
- A pair held fewer than SETTLE_CYCLES samples is discarded with no outputs.
- All outputs are registered. Pulses are exactly one cycle wide. At most one of frame_valid/seg_err/anode_err asserts per cycle.

## Structure
- Package seven_seg_pkg:
  - Sixteen glyph constants and SEG_BLANK = 7'h7F, shared with seven_seg_decoder so both ends use one table.
  - ANODE_OFF = 4'hF.
- Sub-module seg_to_hex, combinational: segs in; nibble, legal, blank out.
- Top level holds the input register, counter, commit logic, digit/seen store and output registers.

## Test plan
- Reset: hold reset = 0 two cycles with random pins -> value 0, blank_mask 0, all pulses 0; release, idle pins -> outputs stay 0.
- Clean frame, SETTLE_CYCLES = 4: each pair held 8 cycles -> exactly one frame_valid, value = 16'h1234, blank_mask = 0. Pairs in order:
  - anode 1110 / segs 19
  - 1101 / 30
  - 1011 / 24
  - 0111 / 79
- Glitch rejection: between digits, insert anode 1101 / segs 00 for 3 cycles -> no change to digit 1, no pulse; frame still reports the held-digit values.
- Blank and hex: digits F, blank, A, 0 held 8 cycles each. Pairs:
  - 1110 / 0E
  - 1101 / 7F
  - 1011 / 08
  - 0111 / 40

  Required response: value = 16'h0A0F, blank_mask = 4'b0010.
- Errors: anode 1100 held 5 cycles -> one anode_err pulse, no digit update. Anode 1110 / segs 55 held 5 cycles -> one seg_err pulse, no frame on a subsequent 3-digit completion. Anode 1111 -> no pulse.
- Reset mid-frame: commit digits 0–2, pulse reset, then commit digit 3 only -> no frame_valid, value remains 0.
